// File: rtl/axis_acq_sequencer.sv
// ---------------------------------------------------------------------------
// axis_acq_sequencer
//
// Purpose:
//   Gates an AXI4-Stream sample path between an ADC-side source and a RAM
//   writer. Each enabled sequence first pulses reset_ram to clear the
//   downstream RAM/writer. It then waits for a trigger and passes exactly
//   cfg_frame_len beats, with TLAST on the final beat. A frame length of 0
//   streams continuously until cfg_enable drops. Outside a frame, source
//   beats are accepted and discarded so the ADC side never stalls.
//
// Optional feature:
//   AXIS_ACQ_SEQ_DROP_CNT_EN - when defined, sts_dropped counts the cycles in
//   which the source presented a beat outside RUN. The counter saturates and
//   is cleared on every IDLE->CLEAR. When undefined, sts_dropped is tied to 0.
//
// Ports:
//   aclk, aresetn        clock (rising edge), async active-low reset
//   cfg_enable           level: 1 runs frame sequences, 0 returns to IDLE
//   cfg_frame_len        beats per frame, 0 = continuous
//   trigger              frame start, only sampled in ARMED
//   s_axis_*             slave stream from the ADC side
//   m_axis_*             master stream towards the RAM writer
//   reset_ram            registered RAM/writer reset pulse, active high
//   sts_state            current state (IDLE=0, CLEAR=1, ARMED=2, RUN=3)
//   sts_count            beats transferred in the current/last frame
//   sts_missed           sticky: trigger seen while in RUN
//   sts_dropped          discarded-beat counter (optional feature)
// ---------------------------------------------------------------------------
module axis_acq_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int RAM_RST_CYCLES   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_frame_len,
  input  logic                        trigger,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        reset_ram,
  output logic [1:0]                  sts_state,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        sts_missed,
  output logic [CNTR_WIDTH-1:0]       sts_dropped
);

  // The reset-pulse counter only has to hold RAM_RST_CYCLES-1 down to 0.
  localparam int RST_W = (RAM_RST_CYCLES > 1) ? $clog2(RAM_RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]      RST_LOAD = RST_W'(RAM_RST_CYCLES - 1);
  localparam logic [RST_W-1:0]      RST_ONE  = RST_W'(1);
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [RST_W-1:0]      rst_cnt;
  logic [CNTR_WIDTH-1:0] len_reg;
  logic                  in_run;
  logic                  beat;
  logic                  at_last;

  assign in_run  = (state == RUN);
  assign beat    = in_run & s_axis_tvalid & m_axis_tready;
  // The beat currently on the bus is the final one of a finite frame.
  assign at_last = (len_reg != '0) && (sts_count == (len_reg - CNT_ONE));

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Dropping cfg_enable wins over every other transition,
  // including a trigger in ARMED and the end of the reset pulse in CLEAR.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_enable) state_next = CLEAR;
      end
      CLEAR: begin
        if (!cfg_enable)        state_next = IDLE;
        else if (rst_cnt == '0) state_next = ARMED;
      end
      ARMED: begin
        if (!cfg_enable)  state_next = IDLE;
        else if (trigger) state_next = RUN;
      end
      RUN: begin
        if (!cfg_enable)          state_next = IDLE;
        else if (beat && at_last) state_next = CLEAR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stream outputs. The path is combinational while in RUN. Outside RUN the
  // source is always ready, so its beats are swallowed instead of stalled.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b1;
    if (in_run) begin
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tlast  = at_last;
      s_axis_tready = m_axis_tready;
    end
  end

  assign m_axis_tdata = s_axis_tdata;
  assign sts_state    = state;

  // Datapath registers.
  // - reset_ram is registered from the next state, so it is high exactly
  //   while the state register sits in CLEAR.
  // - rst_cnt is reloaded on every entry into CLEAR, from IDLE or from RUN.
  // - len_reg is captured only on the ARMED->RUN transition.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reset_ram  <= 1'b0;
      rst_cnt    <= '0;
      len_reg    <= '0;
      sts_count  <= '0;
      sts_missed <= 1'b0;
    end else begin
      reset_ram <= (state_next == CLEAR);

      if ((state_next == CLEAR) && (state != CLEAR)) begin
        rst_cnt <= RST_LOAD;
      end else if ((state == CLEAR) && (rst_cnt != '0)) begin
        rst_cnt <= rst_cnt - RST_ONE;
      end

      if ((state == ARMED) && (state_next == RUN)) begin
        sts_count <= '0;
        len_reg   <= cfg_frame_len;
      end else if (beat) begin
        sts_count <= sts_count + CNT_ONE;
      end

      if ((state == IDLE) && (state_next == CLEAR)) begin
        sts_missed <= 1'b0;
      end else if (in_run && trigger) begin
        sts_missed <= 1'b1;
      end
    end
  end

`ifdef AXIS_ACQ_SEQ_DROP_CNT_EN
  logic [CNTR_WIDTH-1:0] drop_cnt;

  // Counts source beats swallowed outside RUN and saturates at all-ones.
  // A new sequence started from IDLE clears it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt <= '0;
    end else if ((state == IDLE) && (state_next == CLEAR)) begin
      drop_cnt <= '0;
    end else if (s_axis_tvalid && !in_run && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  assign sts_dropped = drop_cnt;
`else
  assign sts_dropped = '0;
`endif

endmodule
